// File: rtl/tower_datapath.sv
// Tower-stacking datapath: block position, row/score/chance counters and the
// c/o condition flags. Optional SPEEDUP_EN shortens the shift period as rows climb.
module tower_datapath #(
   parameter int X_W          = 8,
   parameter int Y_W          = 7,
   parameter int SCREEN_W     = 160,
   parameter int BLOCK_W      = 20,
   parameter int BLOCK_H      = 8,
   parameter int Y_BASE       = 112,
   parameter int X_START      = 0,
   parameter int SPEED_DIV    = 16,
   parameter int ROW_MAX      = 13,
   parameter int CHANCES_INIT = 3,
   parameter int SCORE_W      = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld_x,
   input  logic               ld_y,
   input  logic               ld_d,
   input  logic               enable,
   input  logic               save_x,
   input  logic               inc_row,
   input  logic               inc_score,
   input  logic               dec_chances,
   input  logic [1:0]         game_status,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic [X_W-1:0]     prev_x,
   output logic [3:0]         row,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         chances,
   output logic               c,
   output logic               o
);

   localparam int XMAX = SCREEN_W - BLOCK_W;
   localparam int TW   = $clog2(SPEED_DIV + 1);

   logic          dir;
   logic          armed;
   logic [TW-1:0] tick;
   logic [TW-1:0] p_last;
   logic          step;
   logic          newgame;
   logic [3:0]    row_eff;
   logic [Y_W-1:0] y_load;
   logic [X_W:0]  diff;

   always_comb begin
`ifdef SPEEDUP_EN
      if (SPEED_DIV > 2 * int'(row) + 2)
         p_last = TW'(SPEED_DIV - 1 - 2 * int'(row));
      else
         p_last = TW'(1);
`else
      p_last = TW'(SPEED_DIV - 1);
`endif
   end

   // >= so a row change that shortens the period never strands tick past the end
   assign step    = enable && !ld_x && (tick >= p_last);
   assign newgame = ld_x && armed;
   assign row_eff = newgame ? 4'd0 : row;
   assign y_load  = Y_W'(Y_BASE - int'(row_eff) * BLOCK_H);

   always_comb begin
      if (x >= prev_x)
         diff = {1'b0, x} - {1'b0, prev_x};
      else
         diff = {1'b0, prev_x} - {1'b0, x};
   end

   assign o = diff < (X_W+1)'(BLOCK_W);
   assign c = chances != 2'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         x       <= X_W'(X_START);
         prev_x  <= X_W'(X_START);
         y       <= Y_W'(Y_BASE);
         dir     <= 1'b0;
         row     <= 4'd0;
         score   <= '0;
         chances <= 2'(CHANCES_INIT);
         tick    <= '0;
         armed   <= 1'b0;
      end else begin
         if (ld_x || !enable || step)
            tick <= '0;
         else
            tick <= tick + 1'b1;

         if (ld_x)
            x <= X_W'(X_START);
         else if (step) begin
            if (!dir)
               x <= (x == X_W'(XMAX)) ? x - 1'b1 : x + 1'b1;
            else
               x <= (x == '0) ? x + 1'b1 : x - 1'b1;
         end

         if (ld_d)
            dir <= 1'b0;
         else if (step) begin
            if (!dir && x == X_W'(XMAX))
               dir <= 1'b1;
            else if (dir && x == '0)
               dir <= 1'b0;
         end

         if (ld_y)
            y <= y_load;

         if (newgame)
            prev_x <= X_W'(X_START);
         else if (save_x)
            prev_x <= x;

         if (newgame)
            row <= 4'd0;
         else if (inc_row && row != 4'(ROW_MAX))
            row <= row + 4'd1;

         if (newgame)
            score <= '0;
         else if (inc_score && score != '1)
            score <= score + 1'b1;

         if (newgame)
            chances <= 2'(CHANCES_INIT);
         else if (dec_chances && chances != 2'd0)
            chances <= chances - 2'd1;

         if (newgame)
            armed <= 1'b0;
         else if (game_status == 2'b10)
            armed <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tower_datapath.sv
// Scoreboard bench for tower_datapath with SPEED_DIV=4, SCREEN_W=40, BLOCK_W=8.
module tb_tower_datapath;

   localparam int X_W = 8;
   localparam int Y_W = 7;

   logic           clk = 1'b0;
   logic           reset;
   logic           ld_x, ld_y, ld_d, enable, save_x;
   logic           inc_row, inc_score, dec_chances;
   logic [1:0]     game_status;
   logic [X_W-1:0] x, prev_x;
   logic [Y_W-1:0] y;
   logic [3:0]     row;
   logic [7:0]     score;
   logic [1:0]     chances;
   logic           c, o;

   typedef enum int {F_X, F_Y, F_PX, F_ROW, F_SCORE, F_CH, F_C, F_O} field_t;
   typedef struct {
      string  name;
      field_t f;
      int     val;
   } exp_t;

   exp_t q[$];
   int   total  = 0;
   int   passed = 0;

   tower_datapath #(
      .SPEED_DIV(4),
      .SCREEN_W (40),
      .BLOCK_W  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_x       (ld_x),
      .ld_y       (ld_y),
      .ld_d       (ld_d),
      .enable     (enable),
      .save_x     (save_x),
      .inc_row    (inc_row),
      .inc_score  (inc_score),
      .dec_chances(dec_chances),
      .game_status(game_status),
      .x          (x),
      .y          (y),
      .prev_x     (prev_x),
      .row        (row),
      .score      (score),
      .chances    (chances),
      .c          (c),
      .o          (o)
   );

   always #5 clk = ~clk;

   function automatic int actual(field_t f);
      case (f)
         F_X:     return int'(x);
         F_Y:     return int'(y);
         F_PX:    return int'(prev_x);
         F_ROW:   return int'(row);
         F_SCORE: return int'(score);
         F_CH:    return int'(chances);
         F_C:     return int'(c);
         default: return int'(o);
      endcase
   endfunction

   // monitor: outputs are registered, so negedge sees the settled post-edge state
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         int   a;
         e = q.pop_front();
         a = actual(e.f);
         total++;
         if (a == e.val)
            passed++;
         else
            $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
      end
   end

   task automatic expect_v(string name, field_t f, int val);
      exp_t e;
      e.name = name;
      e.f    = f;
      e.val  = val;
      q.push_back(e);
   endtask

   task automatic clr();
      ld_x = 0; ld_y = 0; ld_d = 0; save_x = 0;
      inc_row = 0; inc_score = 0; dec_chances = 0;
      game_status = 2'b00;
   endtask

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      clr();
   endtask

   task automatic expect_reset(string tag);
      expect_v({tag, "_x"}, F_X, 0);
      expect_v({tag, "_y"}, F_Y, 112);
      expect_v({tag, "_px"}, F_PX, 0);
      expect_v({tag, "_row"}, F_ROW, 0);
      expect_v({tag, "_score"}, F_SCORE, 0);
      expect_v({tag, "_ch"}, F_CH, 3);
      expect_v({tag, "_c"}, F_C, 1);
      expect_v({tag, "_o"}, F_O, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      clr();
      enable = 0;
      reset  = 1;
      cyc();
      reset = 0;
      expect_reset("rst");

      // 1: stepping every 4th cycle
      enable = 1;
      cyc(3);  expect_v("t1_x3", F_X, 0);
      cyc(1);  expect_v("t1_x4", F_X, 1);
      cyc(16); expect_v("t1_x20", F_X, 5);
      expect_v("t1_c", F_C, 1);
      expect_v("t1_o5", F_O, 1);
      cyc(12); expect_v("t1_x8", F_X, 8);
      expect_v("t1_o8", F_O, 0);

      // 2: bounce at right and left edges
      cyc(96);  expect_v("t2_x32", F_X, 32);
      cyc(4);   expect_v("t2_x31", F_X, 31);
      cyc(124); expect_v("t2_x0", F_X, 0);
      cyc(4);   expect_v("t2_x1", F_X, 1);
      cyc(4);   expect_v("t2_x2", F_X, 2);
      cyc(32);  expect_v("t2_x10", F_X, 10);

      // 3: save_x, row 2, combined loads
      enable = 0;
      save_x = 1;
      cyc();
      expect_v("t3_px", F_PX, 10);
      inc_row = 1; cyc();
      inc_row = 1; cyc();
      expect_v("t3_row2", F_ROW, 2);
      ld_x = 1; ld_y = 1; ld_d = 1;
      cyc();
      expect_v("t3_x0", F_X, 0);
      expect_v("t3_y96", F_Y, 96);
      expect_v("t3_px10", F_PX, 10);
      expect_v("t3_o0", F_O, 0);
      enable = 1;
      cyc(8); expect_v("t3_x2", F_X, 2);
      expect_v("t3_o_d8", F_O, 0);
      cyc(4); expect_v("t3_x3", F_X, 3);
      expect_v("t3_o_d7", F_O, 1);
      enable = 0;

      // 4: chances and score saturation
      dec_chances = 1; cyc();
      expect_v("t4_ch2", F_CH, 2); expect_v("t4_c2", F_C, 1);
      dec_chances = 1; cyc();
      expect_v("t4_ch1", F_CH, 1); expect_v("t4_c1", F_C, 1);
      dec_chances = 1; cyc();
      expect_v("t4_ch0", F_CH, 0); expect_v("t4_c0", F_C, 0);
      dec_chances = 1; cyc();
      expect_v("t4_ch0b", F_CH, 0); expect_v("t4_c0b", F_C, 0);
      for (int i = 0; i < 255; i++) begin
         inc_score = 1;
         cyc();
      end
      expect_v("t4_s255", F_SCORE, 255);
      inc_score = 1; cyc();
      expect_v("t4_s_sat", F_SCORE, 255);

      // 5: new game arming
      game_status = 2'b10; cyc();
      expect_v("t5_row_kept", F_ROW, 2);
      expect_v("t5_score_kept", F_SCORE, 255);
      ld_x = 1; ld_y = 1; cyc();
      expect_v("t5_row0", F_ROW, 0);
      expect_v("t5_score0", F_SCORE, 0);
      expect_v("t5_ch3", F_CH, 3);
      expect_v("t5_px0", F_PX, 0);
      expect_v("t5_y_row0", F_Y, 112);
      inc_score = 1; inc_row = 1; cyc();
      ld_x = 1; cyc();
      expect_v("t5_score_kept2", F_SCORE, 1);
      expect_v("t5_row_kept2", F_ROW, 1);
      for (int i = 0; i < 14; i++) begin
         inc_row = 1;
         cyc();
      end
      expect_v("t5_row_sat", F_ROW, 13);
      ld_y = 1; cyc();
      expect_v("t5_y_top", F_Y, 8);

      // 6: shift period vs row, then reset mid-step
      reset = 1; cyc(); reset = 0;
      inc_row = 1; cyc();
      enable = 1;
`ifdef SPEEDUP_EN
      cyc(1); expect_v("t6_r1_x0", F_X, 0);
      cyc(1); expect_v("t6_r1_x1", F_X, 1);
`else
      cyc(3); expect_v("t6_r1_x0", F_X, 0);
      cyc(1); expect_v("t6_r1_x1", F_X, 1);
`endif
      enable = 0;
      for (int i = 0; i < 4; i++) begin
         inc_row = 1;
         cyc();
      end
      expect_v("t6_row5", F_ROW, 5);
      enable = 1;
`ifdef SPEEDUP_EN
      cyc(1); expect_v("t6_r5_x1", F_X, 1);
      cyc(1); expect_v("t6_r5_x2", F_X, 2);
`else
      cyc(3); expect_v("t6_r5_x1", F_X, 1);
      cyc(1); expect_v("t6_r5_x2", F_X, 2);
`endif
      save_x = 1; inc_score = 1; dec_chances = 1;
      cyc();
      reset = 1; save_x = 1; inc_score = 1;
      cyc();
      reset = 0;
      expect_reset("t6_rst");
      cyc(3); expect_v("t6_post_x0", F_X, 0);
      cyc(1); expect_v("t6_post_x1", F_X, 1);
      enable = 0;

      cyc(2);
      if (q.size() != 0) begin
         total++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
